test_pattern_gen: RTL and testbench

Parametrised video test-pattern generator for the DVI transmit path. Sits between the VESA timing generator and the DVI/TMDS transmitter, in the pixel-clock domain. Consumes raster position and sync/enable, produces registered RGB plus delay-matched sync/enable. Supersedes the fixed 8-colour bar logic with four selectable patterns, frame-synchronous mode switching and optional per-frame bar scrolling.

---
 rtl/test_pattern_gen.sv | 126 ++++++++++++
 tb/tb_test_pattern_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: video test-pattern generator for the DVI transmit path.
// Takes raster position and sync/enable from the timing generator and
// produces registered RGB with syncs/enable delayed by the same single stage.
// Ports:
//   pix_clk            pixel clock (sole clock)
//   resetn             asynchronous active-low reset
//   column, row        active-area x/y position
//   hsync_in, vsync_in horizontal / vertical (active-high) sync in
//   de_in              data enable in
//   mode               pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
//   scroll_en          per-frame bar scrolling enable
//   solid_rgb          {r,g,b} colour for solid mode
//   r, g, b            pixel colour out
//   hsync, vsync, de   syncs/enable aligned with r/g/b
//   frame_cnt          frames seen since reset
module test_pattern_gen #(
    parameter int COLOR_BITS   = 8,
    parameter int BAR_WIDTH    = 160,
    parameter int CHECKER_LOG2 = 5,
    parameter int GRAD_SHIFT   = 2,
    parameter int SCROLL_SHIFT = 4
) (
    input  logic                    pix_clk,
    input  logic                    resetn,
    input  logic [10:0]             column,
    input  logic [10:0]             row,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    de_in,
    input  logic [1:0]              mode,
    input  logic                    scroll_en,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    output logic [COLOR_BITS-1:0]   r,
    output logic [COLOR_BITS-1:0]   g,
    output logic [COLOR_BITS-1:0]   b,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic [15:0]             frame_cnt
);
    localparam logic [10:0] BAR_LAST = 11'(BAR_WIDTH - 1);

    logic                    vsync_q;
    logic                    armed;
    logic                    frame_start;
    logic [1:0]              mode_q;
    logic [3*COLOR_BITS-1:0] solid_q;
    logic                    scroll_q;
    logic [10:0]             bar_cnt;
    logic [2:0]              bar_idx;
    logic [2:0]              bar_base;
    logic [COLOR_BITS-1:0]   grad;
    logic [3*COLOR_BITS-1:0] bar_rgb;
    logic [3*COLOR_BITS-1:0] chk_rgb;
    logic [3*COLOR_BITS-1:0] grad_rgb;
    logic [3*COLOR_BITS-1:0] pix_rgb;

    // armed stays low until vsync_in has been seen low after reset, so a
    // release of reset in the middle of a vsync pulse is not taken as a
    // frame boundary.
    assign frame_start = vsync_in & ~vsync_q & armed;
    assign bar_base    = scroll_q ? frame_cnt[SCROLL_SHIFT+2:SCROLL_SHIFT] : 3'd0;

    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            vsync_q   <= 1'b0;
            armed     <= 1'b0;
            mode_q    <= 2'd0;
            solid_q   <= '0;
            scroll_q  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            vsync_q <= vsync_in;
            armed   <= armed | ~vsync_in;
            if (frame_start) begin
                mode_q    <= mode;
                solid_q   <= solid_rgb;
                scroll_q  <= scroll_en;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Bar position restarts from bar_base on every blanking cycle, so the
    // in-progress line is never disturbed by a frame boundary during de_in.
    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            bar_cnt <= 11'd0;
            bar_idx <= 3'd0;
        end else if (!de_in) begin
            bar_cnt <= 11'd0;
            bar_idx <= bar_base;
        end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= 11'd0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_cnt <= bar_cnt + 11'd1;
        end
    end

    assign grad     = COLOR_BITS'(column >> GRAD_SHIFT);
    assign bar_rgb  = {{COLOR_BITS{bar_idx[2]}}, {COLOR_BITS{bar_idx[1]}}, {COLOR_BITS{bar_idx[0]}}};
    assign chk_rgb  = {(3*COLOR_BITS){column[CHECKER_LOG2] ^ row[CHECKER_LOG2]}};
    assign grad_rgb = {grad, grad, grad};

    always_comb begin
        pix_rgb = !de_in         ? '0       :
                  mode_q == 2'd0 ? bar_rgb  :
                  mode_q == 2'd1 ? chk_rgb  :
                  mode_q == 2'd2 ? grad_rgb : solid_q;
    end

    always_ff @(posedge pix_clk or negedge resetn) begin
        if (!resetn) begin
            {r, g, b} <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            de        <= 1'b0;
        end else begin
            {r, g, b} <= pix_rgb;
            hsync     <= hsync_in;
            vsync     <= vsync_in;
            de        <= de_in;
        end
    end
endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: randomized self-checking bench for test_pattern_gen.
module tb_test_pattern_gen;
    localparam int BW = 160;
    localparam int CL = 5;
    localparam int GS = 2;
    localparam int SS = 4;

    logic        pix_clk = 1'b0;
    logic        resetn = 1'b1;
    logic [10:0] column = '0;
    logic [10:0] row = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        de_in = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        scroll_en = 1'b0;
    logic [23:0] solid_rgb = '0;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, de;
    logic [15:0] frame_cnt;

    test_pattern_gen dut (
        .pix_clk(pix_clk), .resetn(resetn), .column(column), .row(row),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .mode(mode),
        .scroll_en(scroll_en), .solid_rgb(solid_rgb), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_cnt(frame_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level settings latched on vsync rising edges,
    // bar colour derived from pixel count since the line started.
    int          m_frame, m_mode, m_pix, m_base;
    logic [23:0] m_solid;
    bit          m_scroll, m_vprev, m_armed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int c, input int rr);
        int idx;
        logic [7:0] gv;
        idx = (m_base + m_pix / BW) % 8;
        gv  = 8'((c >> GS) & 255);
        return m_mode == 0 ? {((idx >> 2) & 1) != 0 ? 8'hFF : 8'h00,
                              ((idx >> 1) & 1) != 0 ? 8'hFF : 8'h00,
                              (idx & 1) != 0 ? 8'hFF : 8'h00} :
               m_mode == 1 ? ((((c >> CL) ^ (rr >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h0) :
               m_mode == 2 ? {gv, gv, gv} : m_solid;
    endfunction

    task automatic model_reset();
        m_frame = 0; m_mode = 0; m_pix = 0; m_base = 0;
        m_solid = '0; m_scroll = 0; m_vprev = 0; m_armed = 0;
    endtask

    task automatic cycle(input int c, input int rr, input bit h, input bit v, input bit d);
        logic [26:0] exp;
        c  = c & 2047;
        rr = rr & 2047;
        column = 11'(c); row = 11'(rr); hsync_in = h; vsync_in = v; de_in = d;
        exp = {d ? model_rgb(c, rr) : 24'h0, h, v, d};
        if (d) m_pix++;
        else begin
            m_pix  = 0;
            m_base = m_scroll ? (m_frame >> SS) & 7 : 0;
        end
        if (v && !m_vprev && m_armed) begin
            m_mode   = int'(mode);
            m_solid  = solid_rgb;
            m_scroll = scroll_en;
            m_frame  = (m_frame + 1) & 16'hFFFF;
        end
        m_armed = m_armed | !v;
        m_vprev = v;
        @(posedge pix_clk);
        #1;
        check("pixel", 32'({r, g, b, hsync, vsync, de}), 32'(exp));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    endtask

    task automatic line(input int width, input int rr, input int col_off);
        for (int i = 0; i < 4; i++) cycle(0, rr, i < 2, 0, 0);
        for (int x = 0; x < width; x++) cycle(x + col_off, rr, 0, 0, 1);
    endtask

    task automatic frame(input int nlines, input int width, input int col_off);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0);
        for (int l = 0; l < nlines; l++) line(width, l, col_off);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        check("reset_out", 32'({r, g, b, hsync, vsync, de}), 32'h0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        model_reset();
        @(posedge pix_clk);
        @(posedge pix_clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge pix_clk);
        #1;
        do_reset();

        // Bars over a 1280-wide line, no scrolling.
        mode = 2'd0; scroll_en = 1'b0;
        frame(2, 1280, 0);

        // Mid-frame switch to checker: no effect until the next boundary.
        mode = 2'd1;
        line(400, 2, 0);
        frame(33, 64, 0);

        // Gradient across the 1023/1024 column wrap.
        mode = 2'd2;
        frame(1, 1100, 0);

        // Solid colour, blanking must stay black.
        mode = 2'd3; solid_rgb = 24'h123456;
        frame(2, 50, 0);

        // Scrolling bars, past frame counts 16 and 128.
        mode = 2'd0; scroll_en = 1'b1;
        while (m_frame < 130) frame(1, 200, 0);
        scroll_en = 1'b0;

        // Random frames with random mid-frame input changes.
        for (int f = 0; f < 25; f++) begin
            mode      = 2'($urandom_range(0, 3));
            scroll_en = 1'($urandom_range(0, 1));
            solid_rgb = 24'($urandom);
            frame($urandom_range(1, 3), $urandom_range(1, 300), $urandom_range(0, 2047));
            mode      = 2'($urandom_range(0, 3));
            solid_rgb = 24'($urandom);
            line($urandom_range(1, 200), 5, $urandom_range(0, 2047));
        end

        // Frame boundary in the middle of an active line.
        mode = 2'd0; scroll_en = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        for (int x = 0; x < 400; x++) cycle(x, 0, 0, x >= 170, 1);

        // Reset mid-line with vsync high; no boundary until vsync falls and rises.
        do_reset();
        for (int x = 0; x < 200; x++) cycle(x, 0, 0, 1, 1);
        check("frame_cnt_after_reset", 32'(frame_cnt), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        frame(1, 180, 0);
        check("frame_cnt_first_frame", 32'(frame_cnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
